// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-port round-robin byte-mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_DW = 8;

  // One-hot owner vector for a state; IDLE maps to no owner.
  function automatic logic [1:0] owner_of(input arb_state_t s);
    logic [1:0] o;
    o = 2'b00;
    if (s == OWN0) o = 2'b01;
    if (s == OWN1) o = 2'b10;
    return o;
  endfunction

endpackage

// File: rtl/rr2_next.sv
// Next-state logic of the two-port round-robin arbiter with burst allowance.
module rr2_next
  import mux_arb_pkg::*;
(
  input  arb_state_t state,
  input  logic       in0_valid,
  input  logic       in1_valid,
  input  logic       last_owner,
  input  logic       burst_done,
  output arb_state_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          next_state = last_owner ? OWN0 : OWN1;
        end else if (in0_valid) begin
          next_state = OWN0;
        end else if (in1_valid) begin
          next_state = OWN1;
        end
      end
      OWN0: begin
        // An owner that runs dry hands over directly, without passing through IDLE.
        if (!in0_valid) begin
          next_state = in1_valid ? OWN1 : IDLE;
        end else if (burst_done && in1_valid) begin
          next_state = OWN1;
        end
      end
      OWN1: begin
        if (!in1_valid) begin
          next_state = in0_valid ? OWN0 : IDLE;
        end else if (burst_done && in0_valid) begin
          next_state = OWN0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with burst allowance feeding a 2:1 byte mux into a
// one-entry registered output stage with valid/ready handshake.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    grant,
  output logic          sel
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  arb_state_t    state_reg;
  arb_state_t    state_next;
  logic [CW-1:0] beat_cnt_reg;
  logic          last_owner_reg;
  logic          out_valid_reg;
  logic [DW-1:0] out_data_reg;

  logic          slot_free;
  logic [1:0]    own_vec;
  logic [1:0]    valid_vec;
  logic [1:0]    ready_vec;
  logic          accept;
  logic          burst_done;
  logic [DW-1:0] mux_data;

  // grant and sel come straight off the state register, never from inputs.
  assign own_vec   = owner_of(state_reg);
  assign grant     = own_vec;
  assign sel       = (state_reg == OWN1);
  assign slot_free = !out_valid_reg || out_ready;
  assign valid_vec = {in1_valid, in0_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi] = own_vec[gi] & slot_free;
    end
  endgenerate

  assign in0_ready  = ready_vec[0];
  assign in1_ready  = ready_vec[1];
  assign accept     = |(ready_vec & valid_vec);
  assign burst_done = accept && (beat_cnt_reg == LAST_BEAT);
  assign mux_data   = sel ? in1_data : in0_data;

  rr2_next u_next (
    .state      (state_reg),
    .in0_valid  (in0_valid),
    .in1_valid  (in1_valid),
    .last_owner (last_owner_reg),
    .burst_done (burst_done),
    .next_state (state_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= '0;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        beat_cnt_reg <= '0;
        if (state_next == OWN0) last_owner_reg <= 1'b0;
        if (state_next == OWN1) last_owner_reg <= 1'b1;
      end else if (accept) begin
        // Wrapping at the burst limit keeps a lone streamer running indefinitely.
        beat_cnt_reg <= burst_done ? '0 : beat_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= mux_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter with hand-computed expectations.
module tb_mux_rr_arbiter;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_valid, in1_valid, out_ready;
  logic [DW-1:0] in0_data, in1_data;
  logic          in0_ready, in1_ready, out_valid, sel;
  logic [DW-1:0] out_data;
  logic [1:0]    grant;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic [1:0] g;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v0, logic [7:0] d0, logic v1, logic [7:0] d1, logic ordy,
                              logic [1:0] g, logic r0, logic r1, logic ov, logic [7:0] od);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.g = g; v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " grant"}, 32'(grant), 32'h0);
    check({tag, " sel"}, 32'(sel), 32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " out_data"}, 32'(out_data), 32'h0);
    check({tag, " in0_ready"}, 32'(in0_ready), 32'h0);
    check({tag, " in1_ready"}, 32'(in1_ready), 32'h0);
  endtask

  logic [7:0] exp3 [12];
  logic [7:0] got3 [$];

  initial begin
    // Port-0-only stream past BURST_LEN, then a 3-cycle output stall.
    vecs[0]  = mk(1, 8'h10, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 8'h10, 0, 8'h00, 1, 2'b01, 1, 0, 0, 8'h00);
    vecs[2]  = mk(1, 8'h11, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h10);
    vecs[3]  = mk(1, 8'h12, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h11);
    vecs[4]  = mk(1, 8'h13, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h12);
    vecs[5]  = mk(1, 8'h14, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h13);
    vecs[6]  = mk(1, 8'h15, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h14);
    vecs[7]  = mk(0, 8'h00, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h15);
    vecs[8]  = mk(0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h15);
    vecs[9]  = mk(1, 8'h20, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h15);
    vecs[10] = mk(1, 8'h20, 0, 8'h00, 1, 2'b01, 1, 0, 0, 8'h15);
    vecs[11] = mk(1, 8'h21, 0, 8'h00, 0, 2'b01, 0, 0, 1, 8'h20);
    vecs[12] = mk(1, 8'h21, 0, 8'h00, 0, 2'b01, 0, 0, 1, 8'h20);
    vecs[13] = mk(1, 8'h21, 0, 8'h00, 0, 2'b01, 0, 0, 1, 8'h20);
    vecs[14] = mk(1, 8'h21, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h20);
    vecs[15] = mk(1, 8'h22, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h21);
    vecs[16] = mk(0, 8'h00, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h22);
    vecs[17] = mk(0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h22);
    // Port 0 releases after 2 beats while port 1 waits; port 0 re-requests mid-burst.
    vecs[18] = mk(1, 8'h30, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h22);
    vecs[19] = mk(1, 8'h30, 1, 8'h40, 1, 2'b01, 1, 0, 0, 8'h22);
    vecs[20] = mk(1, 8'h31, 1, 8'h40, 1, 2'b01, 1, 0, 1, 8'h30);
    vecs[21] = mk(0, 8'h00, 1, 8'h40, 1, 2'b01, 1, 0, 1, 8'h31);
    vecs[22] = mk(1, 8'h32, 1, 8'h40, 1, 2'b10, 0, 1, 0, 8'h31);
    vecs[23] = mk(1, 8'h32, 1, 8'h41, 1, 2'b10, 0, 1, 1, 8'h40);
    vecs[24] = mk(1, 8'h32, 1, 8'h42, 1, 2'b10, 0, 1, 1, 8'h41);
    vecs[25] = mk(1, 8'h32, 1, 8'h43, 1, 2'b10, 0, 1, 1, 8'h42);
    vecs[26] = mk(1, 8'h32, 1, 8'h44, 1, 2'b01, 1, 0, 1, 8'h43);
    vecs[27] = mk(0, 8'h00, 0, 8'h00, 1, 2'b01, 1, 0, 1, 8'h32);
    vecs[28] = mk(0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h32);

    exp3 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
             8'hA4, 8'hA5, 8'hA6, 8'hA7};

    // Reset held while inputs toggle.
    rst = 1'b1;
    in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in0_valid = 1'($urandom); in1_valid = 1'($urandom);
      in0_data = 8'($urandom); in1_data = 8'($urandom); out_ready = 1'($urandom);
      #1;
      check_all_zero("reset");
      $display("reset cycle %0d: grant=%b out_valid=%b", i, grant, out_valid);
    end

    // First tie after reset goes to port 0.
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 1; in1_valid = 1; in0_data = 8'h55; in1_data = 8'h66; out_ready = 1;
    #1;
    check("tie bubble grant", 32'(grant), 32'h0);
    @(negedge clk);
    #1;
    check("tie grant", 32'(grant), 32'h1);
    check("tie in0_ready", 32'(in0_ready), 32'h1);
    check("tie in1_ready", 32'(in1_ready), 32'h0);
    $display("tie: grant=%b in0_ready=%b in1_ready=%b", grant, in0_ready, in1_ready);

    rst = 1'b1;
    in0_valid = 0; in1_valid = 0; out_ready = 0;
    #1;
    check("async reset grant", 32'(grant), 32'h0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in0_valid = vecs[i].v0; in0_data = vecs[i].d0;
      in1_valid = vecs[i].v1; in1_data = vecs[i].d1;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].g));
      check($sformatf("vec%0d sel", i), 32'(sel), 32'(vecs[i].g == 2'b10));
      check($sformatf("vec%0d in0_ready", i), 32'(in0_ready), 32'(vecs[i].r0));
      check($sformatf("vec%0d in1_ready", i), 32'(in1_ready), 32'(vecs[i].r1));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].od));
      $display("vec %0d: grant=%b rdy=%b%b out_valid=%b out_data=%h",
               i, grant, in1_ready, in0_ready, out_valid, out_data);
    end

    // Both ports stream continuously from a fresh reset.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    begin
      int a_cnt, b_cnt, first, last;
      a_cnt = 0; b_cnt = 0; first = -1; last = -1;
      for (int c = 0; c < 40 && got3.size() < 12; c++) begin
        @(negedge clk);
        in0_valid = 1; in0_data = 8'(8'hA0 + a_cnt);
        in1_valid = 1; in1_data = 8'(8'hB0 + b_cnt);
        out_ready = 1;
        #1;
        if (out_valid) begin
          got3.push_back(out_data);
          if (first < 0) first = c;
          last = c;
        end
        if (in0_ready) a_cnt++;
        if (in1_ready) b_cnt++;
        $display("stream cycle %0d: grant=%b out_valid=%b out_data=%h", c, grant, out_valid, out_data);
      end
      check("stream beat count", 32'(got3.size()), 32'd12);
      for (int k = 0; k < 12 && k < got3.size(); k++) begin
        check($sformatf("stream beat%0d", k), 32'(got3[k]), 32'(exp3[k]));
      end
      check("stream no bubble", 32'(last - first), 32'd11);
    end

    // Reset mid-burst drops the buffered beat immediately.
    check("pre-reset out_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("midburst reset");
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 1; in1_valid = 1; out_ready = 1;
    #1;
    check("post-reset bubble grant", 32'(grant), 32'h0);
    @(negedge clk);
    #1;
    check("post-reset grant", 32'(grant), 32'h1);
    check("post-reset sel", 32'(sel), 32'h0);
    $display("post-reset: grant=%b sel=%b", grant, sel);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
